// File: rtl/rx_wr_tlp_sender_pkg.sv
// Shared TLP field codes and FSM encodings for the Rx-path write engine.
package rx_wr_tlp_sender_pkg;

   localparam logic [1:0] FMT_3DW_DATA = 2'b10;
   localparam logic [1:0] FMT_4DW_DATA = 2'b11;
   localparam logic [4:0] TYPE_MEM     = 5'b00000;
   localparam logic [9:0] MWR_LEN_DW   = 10'd2;
   localparam logic [7:0] TREM_64      = 8'h00;
   localparam logic [7:0] TREM_32      = 8'h0F;

   // One-hot encodings shared with the other TRN engines
   typedef enum logic [7:0] {
      ST_IDLE  = 8'h01,
      ST_BEAT0 = 8'h02,
      ST_BEAT1 = 8'h04,
      ST_BEAT2 = 8'h08
   } state_t;

endpackage

// File: rtl/rx_wr_tlp_sender_mwr_hdr_gen.sv
// Combinational Memory Write header former: builds DW0/DW1 of an MWr TLP.
module mwr_hdr_gen
   import rx_wr_tlp_sender_pkg::*;
(
   input  logic [2:0]  tc,
   input  logic [1:0]  attr,
   input  logic [9:0]  length,
   input  logic [15:0] req_id,
   input  logic [1:0]  fmt,
   output logic [31:0] dw0,
   output logic [31:0] dw1
);

   // TD/EP cleared, tag 0, both byte enables fully set
   assign dw0 = {1'b0, fmt, TYPE_MEM, 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr, 2'b00, length};
   assign dw1 = {req_id, 8'h00, 4'hF, 4'hF};

endmodule

// File: rtl/rx_wr_tlp_sender.sv
// Rx-path engine emitting one 2-DW Memory Write TLP per arbiter grant on the TRN Tx port.
// Optional RX_WR_3DW_HDR_EN: use a 3DW header when the upper address word is zero.
module rx_wr_tlp_sender
   import rx_wr_tlp_sender_pkg::*;
#(
   parameter logic [2:0] TLP_TC   = 3'b000,
   parameter logic [1:0] TLP_ATTR = 2'b00
)(
   input  logic        trn_clk,
   input  logic        reset_n,
   input  logic        rx_turn,
   output logic        rx_driven,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_data,
   output logic        req_ack,
   input  logic [15:0] cfg_completer_id,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   output logic        trn_tsrc_dsc_n,
   input  logic        trn_tdst_rdy_n,
   input  logic [3:0]  trn_tbuf_av
);

   state_t        state_r;
   state_t        state_nxt_s;
   logic [63:2]   addr_r;
   logic [63:0]   data_r;
   logic          use3dw_r;
   logic          use3dw_s;
   logic          start_s;
   logic          beat_ok_s;
   logic [1:0]    fmt_s;
   logic [31:0]   hdr_dw0_s;
   logic [31:0]   hdr_dw1_s;
   logic [63:0]   beat1_s;
   logic [63:0]   beat2_s;
   logic [63:0]   td_d_s;
   logic [7:0]    trem_d_s;
   logic          sof_d_s;
   logic          eof_d_s;
   logic          srdy_d_s;
   logic          driven_d_s;
   logic          ack_d_s;
   logic          unused_s;

   assign unused_s       = ^{trn_tbuf_av[3:2], trn_tbuf_av[0], req_addr[1:0]};
   assign trn_tsrc_dsc_n = 1'b1;

   // A start is refused while the previous ack is still showing
   assign start_s   = rx_turn && req_valid && trn_tbuf_av[1] && !req_ack;
   assign beat_ok_s = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

`ifdef RX_WR_3DW_HDR_EN
   assign use3dw_s = (req_addr[63:32] == 32'h0000_0000);
`else
   assign use3dw_s = 1'b0;
`endif

   assign fmt_s = use3dw_s ? FMT_3DW_DATA : FMT_4DW_DATA;

   mwr_hdr_gen u_hdr_gen (
      .tc     (TLP_TC),
      .attr   (TLP_ATTR),
      .length (MWR_LEN_DW),
      .req_id (cfg_completer_id),
      .fmt    (fmt_s),
      .dw0    (hdr_dw0_s),
      .dw1    (hdr_dw1_s)
   );

   assign beat1_s = use3dw_r ? {addr_r[31:2], 2'b00, data_r[31:0]}
                             : {addr_r[63:32], addr_r[31:2], 2'b00};
   assign beat2_s = use3dw_r ? {data_r[63:32], 32'h0000_0000}
                             : {data_r[31:0], data_r[63:32]};

   // State register and request capture
   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= ST_IDLE;
         addr_r   <= 62'd0;
         data_r   <= 64'd0;
         use3dw_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (start_s && (state_r == ST_IDLE)) begin
            addr_r   <= req_addr[63:2];
            data_r   <= req_data;
            use3dw_r <= use3dw_s;
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:  if (start_s)   state_nxt_s = ST_BEAT0; else state_nxt_s = ST_IDLE;
         ST_BEAT0: if (beat_ok_s) state_nxt_s = ST_BEAT1; else state_nxt_s = ST_BEAT0;
         ST_BEAT1: if (beat_ok_s) state_nxt_s = ST_BEAT2; else state_nxt_s = ST_BEAT1;
         ST_BEAT2: if (beat_ok_s) state_nxt_s = ST_IDLE;  else state_nxt_s = ST_BEAT2;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Next output values; everything holds unless a beat is accepted
   always_comb begin
      td_d_s     = trn_td;
      trem_d_s   = trn_trem_n;
      sof_d_s    = trn_tsof_n;
      eof_d_s    = trn_teof_n;
      srdy_d_s   = trn_tsrc_rdy_n;
      driven_d_s = rx_driven;
      ack_d_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               td_d_s     = {hdr_dw0_s, hdr_dw1_s};
               trem_d_s   = TREM_64;
               sof_d_s    = 1'b0;
               eof_d_s    = 1'b1;
               srdy_d_s   = 1'b0;
               driven_d_s = 1'b1;
            end else begin
               driven_d_s = 1'b0;
            end
         end
         ST_BEAT0: begin
            if (beat_ok_s) begin
               td_d_s  = beat1_s;
               sof_d_s = 1'b1;
            end else begin
               sof_d_s = 1'b0;
            end
         end
         ST_BEAT1: begin
            if (beat_ok_s) begin
               td_d_s   = beat2_s;
               eof_d_s  = 1'b0;
               trem_d_s = use3dw_r ? TREM_32 : TREM_64;
            end else begin
               eof_d_s = 1'b1;
            end
         end
         ST_BEAT2: begin
            if (beat_ok_s) begin
               srdy_d_s   = 1'b1;
               eof_d_s    = 1'b1;
               trem_d_s   = TREM_64;
               driven_d_s = 1'b0;
               ack_d_s    = 1'b1;
            end else begin
               eof_d_s = 1'b0;
            end
         end
         default: begin
            srdy_d_s   = 1'b1;
            sof_d_s    = 1'b1;
            eof_d_s    = 1'b1;
            driven_d_s = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         trn_td         <= 64'd0;
         trn_trem_n     <= TREM_64;
         trn_tsof_n     <= 1'b1;
         trn_teof_n     <= 1'b1;
         trn_tsrc_rdy_n <= 1'b1;
         rx_driven      <= 1'b0;
         req_ack        <= 1'b0;
      end else begin
         trn_td         <= td_d_s;
         trn_trem_n     <= trem_d_s;
         trn_tsof_n     <= sof_d_s;
         trn_teof_n     <= eof_d_s;
         trn_tsrc_rdy_n <= srdy_d_s;
         rx_driven      <= driven_d_s;
         req_ack        <= ack_d_s;
      end
   end

endmodule
